// File: rtl/message_scroller.sv
// Six-character scrolling window over a 16-entry ASCII message buffer,
// feeding one ASCII code per seven-segment digit.
module message_scroller #(
  parameter int TICKS_PER_STEP = 25_000_000,
  parameter int MSG_DEPTH      = 16,
  parameter int NUM_DIGITS     = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [3:0]              wr_addr,
  input  logic [7:0]              wr_data,
  input  logic [4:0]              msg_len,
  input  logic                    run,
  input  logic                    dir,
  input  logic                    clr,
  output logic [8*NUM_DIGITS-1:0] ascii_out,
  output logic [3:0]              pos,
  output logic                    step
);

  localparam int             PW       = $clog2(TICKS_PER_STEP);
  localparam logic [PW-1:0]  TERMINAL = PW'(TICKS_PER_STEP - 1);

  logic [7:0]    msg_mem_reg [MSG_DEPTH];
  logic [7:0]    digit_reg   [NUM_DIGITS];
  logic [3:0]    idx         [NUM_DIGITS];

  logic [PW-1:0] presc_reg, presc_next;
  logic [3:0]    pos_reg, pos_next;
  logic          step_reg, step_next;

  logic [4:0]    len_eff;
  logic          tc;
  logic [3:0]    pos_inc, pos_dec;

  // Out-of-range lengths (0 or above 16) fall back to the full buffer.
  always_comb begin
    len_eff = (msg_len == 5'd0 || msg_len > 5'd16) ? 5'd16 : msg_len;
    tc      = run && (presc_reg == TERMINAL);
    pos_inc = ({1'b0, pos_reg} + 5'd1 == len_eff) ? 4'd0 : pos_reg + 4'd1;
    pos_dec = (pos_reg == 4'd0) ? 4'(len_eff - 5'd1) : pos_reg - 4'd1;
  end

  // clr beats the length check, which beats a regular step.
  always_comb begin
    presc_next = presc_reg;
    pos_next   = pos_reg;
    step_next  = 1'b0;
    if (clr) begin
      presc_next = '0;
      pos_next   = 4'd0;
    end else begin
      step_next = tc;
      if (run)
        presc_next = tc ? '0 : presc_reg + 1'b1;
      if ({1'b0, pos_reg} >= len_eff)
        pos_next = 4'd0;
      else if (tc)
        pos_next = dir ? pos_dec : pos_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg <= '0;
      pos_reg   <= 4'd0;
      step_reg  <= 1'b0;
    end else begin
      presc_reg <= presc_next;
      pos_reg   <= pos_next;
      step_reg  <= step_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MSG_DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          msg_mem_reg[gi] <= 8'h20;
        else if (wr_en && (wr_addr == 4'(gi)))
          msg_mem_reg[gi] <= wr_data;
      end
    end

    // Digit 0 takes pos mod L; each further digit advances by one and wraps at L.
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_first
        assign idx[gi] = 4'({1'b0, pos_reg} % len_eff);
      end else begin : g_next
        assign idx[gi] = ({1'b0, idx[gi-1]} + 5'd1 == len_eff) ? 4'd0 : idx[gi-1] + 4'd1;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          digit_reg[gi] <= 8'h20;
        else
          digit_reg[gi] <= msg_mem_reg[idx[gi]];
      end

      assign ascii_out[8*(NUM_DIGITS-gi)-1 -: 8] = digit_reg[gi];
    end
  endgenerate

  assign pos  = pos_reg;
  assign step = step_reg;

endmodule

// File: tb/tb_message_scroller.sv
// Randomized and directed bench for message_scroller with a queue-based scoreboard
// fed by a behavioural model of the buffer, window and scroll position.
module tb_message_scroller;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [7:0]  wr_data = 8'd0;
  logic [4:0]  msg_len = 5'd6;
  logic        run = 1'b0;
  logic        dir = 1'b0;
  logic        clr = 1'b0;
  logic [47:0] ascii_out;
  logic [3:0]  pos;
  logic        step;

  message_scroller #(.TICKS_PER_STEP(T)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .run(run), .dir(dir), .clr(clr),
    .ascii_out(ascii_out), .pos(pos), .step(step)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] a;
    logic [3:0]  p;
    logic        s;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         tests = 0;
  int         fails = 0;

  logic [7:0] mbuf [16];
  int         mpos = 0;
  int         mpresc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [47:0] window(int p, int len);
    logic [47:0] w;
    w = '0;
    for (int k = 0; k < 6; k++) w[47-8*k -: 8] = mbuf[(p + k) % len];
    return w;
  endfunction

  // Monitor: each falling edge compares the outputs against the oldest expectation.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("mon {ascii,pos,step}", {11'd0, ascii_out, pos, step}, {11'd0, mon_e});
    end
  end

  // Predict the outputs after the coming rising edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    int   len;
    bit   tc;
    if (!reset) begin
      foreach (mbuf[i]) mbuf[i] = 8'h20;
      mpos = 0;
      mpresc = 0;
      e.a = {6{8'h20}};
      e.p = 4'd0;
      e.s = 1'b0;
    end else begin
      len = (msg_len == 0 || msg_len > 16) ? 16 : int'(msg_len);
      e.a = window(mpos, len);
      tc = run && (mpresc == T - 1);
      if (clr) begin
        e.s = 1'b0;
        mpos = 0;
        mpresc = 0;
      end else begin
        e.s = tc;
        if (run) mpresc = tc ? 0 : mpresc + 1;
        if (mpos >= len) mpos = 0;
        else if (tc) mpos = dir ? (mpos + len - 1) % len : (mpos + 1) % len;
      end
      e.p = 4'(mpos);
      if (wr_en) mbuf[wr_addr] = wr_data;
    end
    sbq.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] hello [6];
    int   cnt;
    bit   found;
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C;
    hello[3] = 8'h4C; hello[4] = 8'h4F; hello[5] = 8'h20;
    foreach (mbuf[i]) mbuf[i] = 8'h20;

    @(negedge clk);
    #1;
    chk("reset ascii", ascii_out, 48'h202020202020);
    chk("reset pos", pos, 4'd0);
    tick();
    tick();

    // Idle after reset release: nothing moves.
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step) cnt++;
    end
    chk("idle step count", cnt, 0);
    chk("idle ascii", ascii_out, 48'h202020202020);

    // Load "HELLO ".
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = hello[i];
      tick();
    end
    wr_en = 1'b0;
    tick();
    chk("hello window", ascii_out, 48'h48454C4C4F20);

    // Left scroll.
    run = 1'b1; dir = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (step) found = 1;
    end
    chk("left first step seen", found, 1);
    chk("left first pos", pos, 4'd1);
    tick();
    chk("left first window", ascii_out, 48'h454C4C4F2048);
    cnt = 1;
    for (int i = 0; i < 60 && cnt < 6; i++) begin
      tick();
      if (step) cnt++;
    end
    chk("left six steps", cnt, 6);
    chk("left wrap pos", pos, 4'd0);
    tick();
    chk("left wrap window", ascii_out, 48'h48454C4C4F20);

    // Right scroll from pos 0.
    dir = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (step) found = 1;
    end
    chk("right step seen", found, 1);
    chk("right pos", pos, 4'd5);
    tick();
    chk("right window", ascii_out, 48'h2048454C4C4F);

    // Length shrink below pos.
    msg_len = 5'd16;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (pos == 4'd12) found = 1;
    end
    chk("reached pos 12", found, 1);
    run = 1'b0;
    msg_len = 5'd3;
    tick();
    chk("shrink pos", pos, 4'd0);
    tick();
    chk("len3 window", ascii_out, 48'h48454C48454C);
    msg_len = 5'd0;
    tick();
    tick();
    chk("len0 window", ascii_out, 48'h48454C4C4F20);

    // clr in the terminal-count cycle.
    msg_len = 5'd16; dir = 1'b0; run = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (step) found = 1;
    end
    chk("pre-clr pos", pos, 4'd1);
    for (int i = 0; i < 20 && mpresc != T - 1; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr pos", pos, 4'd0);
    chk("clr step", step, 1'b0);

    // Write to the entry that becomes digit 0 on the same edge as a step.
    for (int i = 0; i < 20 && mpresc != T - 1; i++) tick();
    wr_en = 1'b1; wr_addr = 4'((mpos + 1) % 16); wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    chk("write+step step", step, 1'b1);
    tick();
    chk("write+step digit0", ascii_out[47:40], 8'h5A);

    // Asynchronous reset mid-run.
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b0;
    #1;
    chk("async reset ascii", ascii_out, 48'h202020202020);
    chk("async reset pos", pos, 4'd0);
    chk("async reset step", step, 1'b0);
    tick();
    reset = 1'b1; run = 1'b0;
    tick();
    tick();
    chk("post-reset buffer", ascii_out, 48'h202020202020);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 8'($urandom_range(8'h21, 8'h7E));
      if ($urandom_range(0, 15) == 0) msg_len = 5'($urandom_range(0, 20));
      run     = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      clr     = ($urandom_range(0, 29) == 0);
      reset   = ($urandom_range(0, 149) != 0);
      tick();
    end
    reset = 1'b1; clr = 1'b0; wr_en = 1'b0;

    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/message_scroller.md
Name: message_scroller

Overview:
- Character source for the board's six-digit seven-segment message display.
- Holds a 16-entry ASCII message buffer, written by the host through a simple write port.
- Scrolls a six-character window across the buffer at a programmable step rate.
- Drives six 8-bit ASCII codes, one per HEX digit, each feeding its own per-digit ASCII-to-segment decoder.

Parameters:
- TICKS_PER_STEP, 25_000_000: clock cycles between scroll steps (0.5 s at 50 MHz). Must be at least 2.
- MSG_DEPTH, 16: buffer entries. Fixed at 16; wr_addr and pos are 4 bits.
- NUM_DIGITS, 6: window width in characters.

Ports:
- clk  input  1: system clock; all state changes on the rising edge.
- reset  input  1: asynchronous, active-low reset.
- wr_en  input  1: buffer write strobe.
- wr_addr  input  4: buffer write index.
- wr_data  input  8: ASCII code to write.
- msg_len  input  5: active message length. Values 1..16 are used as given; 0 or >16 are treated as 16.
- run  input  1: 1 = scrolling enabled; 0 = frozen.
- dir  input  1: 0 = scroll left (pos increments); 1 = scroll right (pos decrements).
- clr  input  1: synchronous restart of the scroll.
- ascii_out  output  48: window characters. Digit k occupies [47-8k:40-8k]; k=0 is the leftmost HEX digit.
- pos  output  4: current window start index.
- step  output  1: one-cycle pulse, asserted in the cycle pos changes.

Behaviour:
- Reset, asynchronous, while reset=0:
  - all buffer entries = 8'h20 (space)
  - pos = 0, prescaler = 0, step = 0
  - ascii_out = six copies of 8'h20
- Effective length L = msg_len if 1 <= msg_len <= 16; otherwise L = 16.
- Prescaler, 0..TICKS_PER_STEP-1:
  - increments each cycle while run=1; holds its value while run=0.
  - at terminal count it wraps to 0 and step=1 for that following cycle.
- Scroll step:
  - dir=0: pos <= (pos+1) mod L.
  - dir=1: pos <= (pos==0) ? L-1 : pos-1.
  - Direction is sampled in the terminal-count cycle.
- Length change: if pos >= L in any cycle, pos <= 0 on the next edge. This takes priority over a step in that cycle; step is still pulsed.
- clr=1: pos <= 0 and prescaler <= 0, no step. Has priority over a step and over the length check. Buffer contents are untouched.
- Write: wr_en=1 writes buf[wr_addr] <= wr_data at the edge.
  - wr_addr >= L is still written, but that entry is not displayed.
- Window: ascii_out digit k = buf[(pos+k) mod L], registered from the current buf/pos.
  - Latency: a buffer write or pos change at edge N is visible on ascii_out after edge N+1.
  - Modulo is true modulo, so L < 6 repeats characters; e.g. L=1 shows the same character on all six digits.
- Simultaneous write and step in one cycle: both take effect; ascii_out after the next edge reflects both.
- Write to an entry currently displayed on several digits (L < 6): all of those digits update together.
- No handshake: writes are always accepted; no back-pressure.
- Reset asserted mid-scroll immediately forces the reset values. Scrolling resumes from pos 0 on the first run cycle after release.

Test Plan (bench uses TICKS_PER_STEP=4):
1. Release reset, run=0 -> ascii_out=48'h202020202020, pos=0, step never asserted over 20 cycles.
2. Write "HELLO " (48,45,4C,4C,4F,20) to addr 0..5, msg_len=6 -> two cycles after the last write, ascii_out=48'h48454C4C4F20.
3. Same buffer, run=1, dir=0 -> step every 4th cycle; after the first step ascii_out=48'h454C4C4F2048; after 6 steps pos=0 and the window is back to "HELLO ".
4. Same buffer, dir=1 from pos=0 -> after one step pos=5, ascii_out=48'h2048454C4C4F.
5. msg_len=16 with pos=12, then msg_len=3 -> pos=0 next cycle; ascii_out=48'h48454C48454C. msg_len=0 -> behaves as L=16.
6. clr asserted in the terminal-count cycle -> pos=0, no step. A wr_en on a displayed entry coinciding with a step -> both changes visible after the following edge. reset dropped mid-run -> all outputs return to their reset values immediately.
